// File: rtl/branch_ctrl_pkg.sv
// Shared ISA constants, FSM state encoding and small helpers for the decode-stage branch controller.
package branch_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 6;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 16;

    localparam logic [OP_W-1:0] OP_REGIMM = 6'h01;
    localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE    = 6'h05;
    localparam logic [OP_W-1:0] OP_BLEZ   = 6'h06;
    localparam logic [OP_W-1:0] OP_BGTZ   = 6'h07;

    localparam logic [REG_W-1:0] RT_BLTZ   = 5'h00;
    localparam logic [REG_W-1:0] RT_BGEZ   = 5'h01;
    localparam logic [REG_W-1:0] RT_BLTZAL = 5'h10;
    localparam logic [REG_W-1:0] RT_BGEZAL = 5'h11;

    typedef enum logic [1:0] {
        BRC_IDLE     = 2'd0,
        BRC_WAIT     = 2'd1,
        BRC_REDIRECT = 2'd2
    } brc_state_e;

    function automatic logic is_branch_op(input logic [OP_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ) ||
               (op == OP_BLEZ) || (op == OP_REGIMM);
    endfunction

    function automatic logic needs_rt(input logic [OP_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic is_link(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rt);
        return (op == OP_REGIMM) && ((rt == RT_BLTZAL) || (rt == RT_BGEZAL));
    endfunction

    // Word offset is sign-extended then scaled by 4; the sum wraps modulo 2^32.
    function automatic logic [DATA_W-1:0] branch_target(input logic [DATA_W-1:0] pc_plus4,
                                                        input logic [IMM_W-1:0]  imm);
        logic signed [DATA_W-1:0] off;
        off = {{(DATA_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
        return pc_plus4 + $unsigned(off);
    endfunction

endpackage

// File: rtl/branch_ctrl_eqcmp.sv
// Branch condition comparator: decides whether the ID-stage branch is taken from its operands.
module eqcmp
    import branch_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    input  logic [REG_W-1:0]  rt,
    output logic              take
);

    logic signed [DATA_W-1:0] a_s;
    assign a_s = a;

    always_comb begin
        take = 1'b0;
        case (op)
            OP_BEQ:  take = (a == b);
            OP_BNE:  take = (a != b);
            OP_BGTZ: take = (a_s > 0);
            OP_BLEZ: take = (a_s <= 0);
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BLTZAL: take = (a_s < 0);
                    RT_BGEZ, RT_BGEZAL: take = (a_s >= 0);
                    default:            take = 1'b0;
                endcase
            end
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Decode-stage branch controller: waits for operands, resolves the branch, issues a one-cycle redirect.
// Optional performance counters are built when BRANCH_CTRL_PERF_EN is defined.
module branch_ctrl
    import branch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_op,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [IMM_W-1:0]  id_imm,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              rs_pending,
    input  logic              rt_pending,
    input  logic              pipe_hold,
    output logic              stall_fd,
    output logic              flush_fd,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              link_en,
    output logic              busy,
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_taken,
    output logic [31:0]       perf_stalls
);

    brc_state_e        state, state_nxt;
    logic              br_p0, ready_p0, take_p0, eval_p0;
    logic              stall_c, link_c;
    logic [DATA_W-1:0] target_p1;

    // Stage p0: decode-stage qualification and condition evaluation
    assign br_p0    = id_valid && is_branch_op(id_op);
    assign ready_p0 = !rs_pending && !(needs_rt(id_op) && rt_pending);

    eqcmp u_eqcmp (
        .a    (rs_val),
        .b    (rt_val),
        .op   (id_op),
        .rt   (id_rt),
        .take (take_p0)
    );

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        link_c    = 1'b0;
        eval_p0   = 1'b0;
        case (state)
            BRC_IDLE, BRC_WAIT: begin
                stall_c = br_p0 && !ready_p0;
                if (br_p0 && ready_p0 && !pipe_hold) begin
                    eval_p0   = 1'b1;
                    link_c    = is_link(id_op, id_rt);
                    state_nxt = take_p0 ? BRC_REDIRECT : BRC_IDLE;
                end else if (br_p0 && !pipe_hold) begin
                    state_nxt = BRC_WAIT;
                end else if (!pipe_hold) begin
                    // A branch that leaves ID without resolving is dropped.
                    state_nxt = BRC_IDLE;
                end
            end
            BRC_REDIRECT: begin
                if (!pipe_hold) state_nxt = BRC_IDLE;
            end
            default: state_nxt = BRC_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, including the combinational ones.
    assign stall_fd = stall_c && rst_n;
    assign link_en  = link_c && rst_n;

    // Stage p1: registered branch state and target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BRC_IDLE;
            target_p1 <= '0;
        end else begin
            state <= state_nxt;
            if (eval_p0) target_p1 <= branch_target(id_pc_plus4, id_imm);
        end
    end

    assign pc_redirect = (state == BRC_REDIRECT);
    assign flush_fd    = (state == BRC_REDIRECT) && !pipe_hold;
    assign redirect_pc = target_p1;
    assign busy        = (state != BRC_IDLE);

`ifdef BRANCH_CTRL_PERF_EN
    logic [31:0] br_cnt, tk_cnt, st_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt <= '0;
            tk_cnt <= '0;
            st_cnt <= '0;
        end else if (!pipe_hold) begin
            if (eval_p0)            br_cnt <= br_cnt + 32'd1;
            if (eval_p0 && take_p0) tk_cnt <= tk_cnt + 32'd1;
            if (stall_c)            st_cnt <= st_cnt + 32'd1;
        end
    end

    assign perf_branches = br_cnt;
    assign perf_taken    = tk_cnt;
    assign perf_stalls   = st_cnt;
`else
    assign perf_branches = '0;
    assign perf_taken    = '0;
    assign perf_stalls   = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized branches against a cycle-level model.
module tb_branch_ctrl;

    localparam logic [5:0] T_REGIMM = 6'h01;
    localparam logic [5:0] T_BEQ    = 6'h04;
    localparam logic [5:0] T_BNE    = 6'h05;
    localparam logic [5:0] T_BLEZ   = 6'h06;
    localparam logic [5:0] T_BGTZ   = 6'h07;
    localparam logic [5:0] T_LW     = 6'h23;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_op;
    logic [4:0]  id_rt;
    logic [15:0] id_imm;
    logic [31:0] id_pc_plus4, rs_val, rt_val;
    logic        rs_pending, rt_pending, pipe_hold;
    logic        stall_fd, flush_fd, pc_redirect, link_en, busy;
    logic [31:0] redirect_pc, perf_branches, perf_taken, perf_stalls;

    int          n_chk  = 0;
    int          n_fail = 0;
    int unsigned m_br = 0, m_tk = 0, m_st = 0;

    branch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_op         (id_op),
        .id_rt         (id_rt),
        .id_imm        (id_imm),
        .id_pc_plus4   (id_pc_plus4),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .rs_pending    (rs_pending),
        .rt_pending    (rt_pending),
        .pipe_hold     (pipe_hold),
        .stall_fd      (stall_fd),
        .flush_fd      (flush_fd),
        .pc_redirect   (pc_redirect),
        .redirect_pc   (redirect_pc),
        .link_en       (link_en),
        .busy          (busy),
        .perf_branches (perf_branches),
        .perf_taken    (perf_taken),
        .perf_stalls   (perf_stalls)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_ctl(input string tag, input bit st, input bit rd, input bit fl,
                              input bit lk, input bit bz);
        chk({tag, ".stall_fd"},    32'(stall_fd),    32'(st));
        chk({tag, ".pc_redirect"}, 32'(pc_redirect), 32'(rd));
        chk({tag, ".flush_fd"},    32'(flush_fd),    32'(fl));
        chk({tag, ".link_en"},     32'(link_en),     32'(lk));
        chk({tag, ".busy"},        32'(busy),        32'(bz));
    endtask

    task automatic check_perf(input string tag);
`ifdef BRANCH_CTRL_PERF_EN
        chk({tag, ".perf_branches"}, perf_branches, 32'(m_br));
        chk({tag, ".perf_taken"},    perf_taken,    32'(m_tk));
        chk({tag, ".perf_stalls"},   perf_stalls,   32'(m_st));
`else
        chk({tag, ".perf_branches"}, perf_branches, 32'd0);
        chk({tag, ".perf_taken"},    perf_taken,    32'd0);
        chk({tag, ".perf_stalls"},   perf_stalls,   32'd0);
`endif
    endtask

    // Reference condition from the ISA definitions: sign bit and zero test of rs.
    function automatic bit ref_take(input logic [5:0] op, input logic [4:0] rtf,
                                    input logic [31:0] rs, input logic [31:0] rt);
        bit neg, zero;
        neg  = rs[31];
        zero = (rs == 32'd0);
        if (op == T_BEQ)  return rs == rt;
        if (op == T_BNE)  return rs != rt;
        if (op == T_BGTZ) return !neg && !zero;
        if (op == T_BLEZ) return neg || zero;
        if (op == T_REGIMM && (rtf == 5'd0 || rtf == 5'd16)) return neg;
        if (op == T_REGIMM && (rtf == 5'd1 || rtf == 5'd17)) return !neg;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] pc4, input logic [15:0] imm);
        int off;
        off = int'($signed(imm)) * 4;
        return pc4 + 32'(off);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid   = 1'b0;
        id_op      = T_LW;
        id_rt      = 5'd0;
        rs_pending = 1'b0;
        rt_pending = 1'b0;
        pipe_hold  = 1'b0;
    endtask

    // One branch from first appearance in ID through the cycle after its redirect; entered and left at posedge+1.
    task automatic run_branch(input string tag, input logic [5:0] op, input logic [4:0] rtf,
                              input logic [31:0] rs, input logic [31:0] rtv, input logic [15:0] imm,
                              input logic [31:0] pc4, input int npend, input int nhold,
                              input bit slot_is_br);
        bit          tk, lk, nrt;
        logic [31:0] tgt;
        tk  = ref_take(op, rtf, rs, rtv);
        lk  = (op == T_REGIMM) && (rtf == 5'd16 || rtf == 5'd17);
        nrt = (op == T_BEQ) || (op == T_BNE);
        tgt = ref_target(pc4, imm);

        id_valid = 1'b1; id_op = op; id_rt = rtf; id_imm = imm; id_pc_plus4 = pc4;
        rs_val = rs; rt_val = rtv; pipe_hold = 1'b0;
        for (int i = 0; i < npend; i++) begin
            rs_pending = nrt ? 1'($urandom_range(0, 1)) : 1'b1;
            rt_pending = nrt ? !rs_pending : 1'($urandom_range(0, 1));
            @(negedge clk);
            expect_ctl({tag, ".pend"}, 1'b1, 1'b0, 1'b0, 1'b0, i > 0);
            m_st++;
            step();
        end
        rs_pending = 1'b0;
        rt_pending = nrt ? 1'b0 : 1'($urandom_range(0, 1));
        @(negedge clk);
        expect_ctl({tag, ".eval"}, 1'b0, 1'b0, 1'b0, lk, npend > 0);
        m_br++;
        if (tk) m_tk++;
        step();

        // Delay slot now in ID; a branch here must not be evaluated while redirecting.
        id_op = (slot_is_br && tk) ? T_BEQ : T_LW;
        rs_val = 32'h1234; rt_val = 32'h1234;
        rs_pending = 1'b0; rt_pending = 1'b0;
        if (tk) begin
            pipe_hold = 1'b1;
            for (int i = 0; i < nhold; i++) begin
                @(negedge clk);
                expect_ctl({tag, ".hold"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                chk({tag, ".hold.redirect_pc"}, redirect_pc, tgt);
                step();
            end
            pipe_hold = 1'b0;
            @(negedge clk);
            expect_ctl({tag, ".redir"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            chk({tag, ".redirect_pc"}, redirect_pc, tgt);
            step();
        end else begin
            @(negedge clk);
            expect_ctl({tag, ".slot"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        idle_inputs();
        @(negedge clk);
        expect_ctl({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        id_imm = '0; id_pc_plus4 = '0; rs_val = '0; rt_val = '0;
        #1;
        expect_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.redirect_pc", redirect_pc, 32'd0);
        check_perf("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        run_branch("beq_taken",   T_BEQ,    5'd0,  32'h5, 32'h5, 16'h0004, 32'h100, 0, 0, 1'b0);
        run_branch("bne_nt",      T_BNE,    5'd0,  32'h7, 32'h7, 16'h0010, 32'h200, 0, 0, 1'b0);
        run_branch("bgtz_pend",   T_BGTZ,   5'd0,  32'h1, 32'h0, 16'h0020, 32'h400, 2, 0, 1'b0);
        run_branch("bltzal_nt",   T_REGIMM, 5'd16, 32'h1, 32'h0, 16'hFFFF, 32'h800, 0, 0, 1'b0);
        run_branch("bltzal_tk",   T_REGIMM, 5'd16, 32'h80000000, 32'h0, 16'hFFFF, 32'h800, 0, 0, 1'b1);
        run_branch("blez_hold",   T_BLEZ,   5'd0,  32'h0, 32'h9, 16'h8000, 32'h00010000, 0, 3, 1'b1);
        run_branch("bgez_wrap",   T_REGIMM, 5'd1,  32'h0, 32'h0, 16'h7FFF, 32'hFFFFFFF0, 1, 1, 1'b0);
        check_perf("directed");

        // Branch whose operand never arrives leaves ID: the controller abandons it.
        id_valid = 1'b1; id_op = T_BGTZ; id_rt = 5'd0; rs_val = 32'h3; rs_pending = 1'b1;
        @(negedge clk);
        expect_ctl("drop.pend", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_st++;
        step();
        id_valid = 1'b0;
        @(negedge clk);
        expect_ctl("drop.gone", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle_inputs();
        @(negedge clk);
        expect_ctl("drop.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        for (int n = 0; n < 60; n++) begin
            logic [5:0]  op;
            logic [4:0]  rtf;
            logic [31:0] rs, rtv;
            int          sel;
            sel = $urandom_range(0, 4);
            op  = (sel == 0) ? T_BEQ : (sel == 1) ? T_BNE : (sel == 2) ? T_BGTZ :
                  (sel == 3) ? T_BLEZ : T_REGIMM;
            sel = $urandom_range(0, 4);
            rtf = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd1 : (sel == 2) ? 5'd16 :
                  (sel == 3) ? 5'd17 : 5'd2;
            rtv = $urandom;
            sel = $urandom_range(0, 4);
            rs  = (sel == 0) ? 32'd0 : (sel == 1) ? rtv : (sel == 2) ? 32'h80000000 : $urandom;
            run_branch("rand", op, rtf, rs, rtv, 16'($urandom), {$urandom, 2'b00} & 32'hFFFFFFFC,
                       $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        check_perf("random");

        // Reset while a branch is waiting: outputs drop immediately and nothing is redirected later.
        id_valid = 1'b1; id_op = T_BLEZ; id_rt = 5'd0; rs_val = 32'h0; rs_pending = 1'b1;
        @(negedge clk);
        expect_ctl("rstwait.pend", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        expect_ctl("rstwait.wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_ctl("rstwait.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstwait.redirect_pc", redirect_pc, 32'd0);
        m_br = 0; m_tk = 0; m_st = 0;
        check_perf("rstwait");
        step();
        rs_pending = 1'b0;
        id_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        expect_ctl("rstwait.rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        expect_ctl("rstwait.quiet", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        run_branch("post_beq",  T_BEQ,  5'd0, 32'hA, 32'hA, 16'h0001, 32'h1000, 1, 0, 1'b0);
        run_branch("post_bne",  T_BNE,  5'd0, 32'hA, 32'hB, 16'hFFF0, 32'h2000, 0, 0, 1'b0);
        run_branch("post_bgtz", T_BGTZ, 5'd0, 32'hFFFFFFFF, 32'h0, 16'h0002, 32'h3000, 0, 0, 1'b0);
        check_perf("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
